// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand fetch with writeback bypass, load-use
// interlock, EX back-pressure hold, flush squash and saturating stall/bubble counters.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_reg_write,
   input  logic             in_mem_read,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [4:0]       in_rd,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [7:0]       in_ctrl,
   output logic [4:0]       rf_addr_a,
   output logic [4:0]       rf_addr_b,
   input  logic [XLEN-1:0]  rf_data_a,
   input  logic [XLEN-1:0]  rf_data_b,
   input  logic             wb_en,
   input  logic [4:0]       wb_addr,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             ex_ready,
   input  logic             flush,
   output logic             stall_out,
   output logic             out_valid,
   output logic             out_reg_write,
   output logic             out_mem_read,
   output logic [4:0]       out_rd,
   output logic [XLEN-1:0]  out_a,
   output logic [XLEN-1:0]  out_b,
   output logic [XLEN-1:0]  out_imm,
   output logic [7:0]       out_ctrl,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

   logic             r_valid;
   logic             r_reg_write;
   logic             r_mem_read;
   logic [4:0]       r_rd;
   logic [XLEN-1:0]  r_a;
   logic [XLEN-1:0]  r_b;
   logic [XLEN-1:0]  r_imm;
   logic [7:0]       r_ctrl;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;

   logic             w_hazard;
   logic             w_hold;
   logic             w_bubble;
   logic [XLEN-1:0]  w_op_a;
   logic [XLEN-1:0]  w_op_b;

   assign rf_addr_a = in_rs1;
   assign rf_addr_b = in_rs2;

   // x0 reads as zero; a same-edge writeback must be forwarded because the
   // register file only reflects it after this edge.
   always_comb begin
      w_op_a = rf_data_a;
      if (in_rs1 == 5'd0)                     w_op_a = '0;
      else if (wb_en && (wb_addr == in_rs1))  w_op_a = wb_data;
   end

   always_comb begin
      w_op_b = rf_data_b;
      if (in_rs2 == 5'd0)                     w_op_b = '0;
      else if (wb_en && (wb_addr == in_rs2))  w_op_b = wb_data;
   end

   assign w_hazard  = in_valid && r_valid && r_mem_read && (r_rd != 5'd0) &&
                      ((r_rd == in_rs1) || (r_rd == in_rs2));
   assign w_hold    = r_valid && !ex_ready;
   assign w_bubble  = !flush && !w_hold && w_hazard;
   assign stall_out = !flush && (w_hazard || w_hold);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_rd        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_imm       <= '0;
         r_ctrl      <= '0;
      end else if (flush || (!w_hold && w_hazard)) begin
         // Squash or bubble: clearing mem_read also drops the hazard next cycle.
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end else if (!w_hold) begin
         r_valid     <= in_valid;
         r_reg_write <= in_valid && in_reg_write;
         r_mem_read  <= in_valid && in_mem_read;
         r_rd        <= in_rd;
         r_a         <= w_op_a;
         r_b         <= w_op_b;
         r_imm       <= in_imm;
         r_ctrl      <= in_ctrl;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (stall_out && (r_stall_cnt != L_CNT_MAX))
            r_stall_cnt <= r_stall_cnt + L_CNT_ONE;
         if (w_bubble && (r_bubble_cnt != L_CNT_MAX))
            r_bubble_cnt <= r_bubble_cnt + L_CNT_ONE;
      end
   end

   assign out_valid     = r_valid;
   assign out_reg_write = r_reg_write;
   assign out_mem_read  = r_mem_read;
   assign out_rd        = r_rd;
   assign out_a         = r_a;
   assign out_b         = r_b;
   assign out_imm       = r_imm;
   assign out_ctrl      = r_ctrl;
   assign stall_cnt     = r_stall_cnt;
   assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: scoreboard of expected issued instructions
// plus a bench-side model of stall_out and the saturating counters.
module tb_id_ex_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_reg_write, in_mem_read;
   logic [4:0]       in_rs1, in_rs2, in_rd;
   logic [XLEN-1:0]  in_imm;
   logic [7:0]       in_ctrl;
   logic [4:0]       rf_addr_a, rf_addr_b;
   logic [XLEN-1:0]  rf_data_a, rf_data_b;
   logic             wb_en;
   logic [4:0]       wb_addr;
   logic [XLEN-1:0]  wb_data;
   logic             ex_ready, flush;
   logic             stall_out;
   logic             out_valid, out_reg_write, out_mem_read;
   logic [4:0]       out_rd;
   logic [XLEN-1:0]  out_a, out_b, out_imm;
   logic [7:0]       out_ctrl;
   logic [CNT_W-1:0] stall_cnt, bubble_cnt;

   typedef struct {
      logic             rw;
      logic             mr;
      logic [4:0]       rd;
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      logic [XLEN-1:0]  imm;
      logic [7:0]       ctrl;
   } exp_t;

   exp_t             sb[$];
   exp_t             last;
   int               checks = 0;
   int               errors = 0;
   logic [CNT_W-1:0] exp_stall  = '0;
   logic [CNT_W-1:0] exp_bubble = '0;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_imm(in_imm), .in_ctrl(in_ctrl),
      .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
      .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_ready(ex_ready), .flush(flush), .stall_out(stall_out),
      .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_rd(out_rd), .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_ctrl(out_ctrl),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rw, input logic mr,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [XLEN-1:0] imm, input logic [7:0] ctrl,
                        input logic [XLEN-1:0] da, input logic [XLEN-1:0] db);
      in_valid = v; in_reg_write = rw; in_mem_read = mr;
      in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      in_imm = imm; in_ctrl = ctrl;
      rf_data_a = da; rf_data_b = db;
   endtask

   task automatic push(input logic rw, input logic mr, input logic [4:0] rd,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] imm, input logic [7:0] ctrl);
      exp_t e;
      e.rw = rw; e.mr = mr; e.rd = rd; e.a = a; e.b = b; e.imm = imm; e.ctrl = ctrl;
      sb.push_back(e);
   endtask

   // Checks stall_out before the edge, then advances the counter model.
   task automatic tick(input logic exp_so, input logic exp_bub);
      #1;
      check("stall_out", stall_out, exp_so);
      @(posedge clk);
      if (exp_so && (exp_stall != CNT_MAX))   exp_stall++;
      if (exp_bub && (exp_bubble != CNT_MAX)) exp_bubble++;
      #1;
   endtask

   task automatic cmp_fields(input string tag, input exp_t e);
      check({tag, "_rw"},   out_reg_write, e.rw);
      check({tag, "_mr"},   out_mem_read,  e.mr);
      check({tag, "_rd"},   out_rd,        e.rd);
      check({tag, "_a"},    out_a,         e.a);
      check({tag, "_b"},    out_b,         e.b);
      check({tag, "_imm"},  out_imm,       e.imm);
      check({tag, "_ctrl"}, out_ctrl,      e.ctrl);
   endtask

   task automatic check_issue(input string tag);
      check({tag, "_valid"}, out_valid, 1'b1);
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
         last = sb.pop_front();
         cmp_fields(tag, last);
      end
   endtask

   task automatic check_bubble(input string tag);
      check({tag, "_valid"}, out_valid,     1'b0);
      check({tag, "_rw"},    out_reg_write, 1'b0);
      check({tag, "_mr"},    out_mem_read,  1'b0);
   endtask

   task automatic check_cnts(input string tag);
      check({tag, "_stall_cnt"},  stall_cnt,  exp_stall);
      check({tag, "_bubble_cnt"}, bubble_cnt, exp_bubble);
   endtask

   initial begin
      rst = 1'b1; ex_ready = 1'b1; flush = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0);
      #2;
      check_bubble("reset");
      check_cnts("reset");
      check("rf_addr_a", rf_addr_a, 5'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Bypass of a same-edge writeback on operand A
      drive(1'b1, 1'b1, 1'b0, 5'd10, 5'd0, 5'd4, 32'h100, 8'h11, 32'd5, 32'hDEAD);
      wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h77;
      #1;
      check("rf_addr_a_fwd", rf_addr_a, 5'd10);
      check("rf_addr_b_fwd", rf_addr_b, 5'd0);
      push(1'b1, 1'b0, 5'd4, 32'h77, 32'h0, 32'h100, 8'h11);
      tick(1'b0, 1'b0);
      check_issue("bypass");

      // x0 ignores both the register file and a writeback to x0
      drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd5, 32'h200, 8'h22, 32'h1234, 32'hDEAD);
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h55;
      push(1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h200, 8'h22);
      tick(1'b0, 1'b0);
      check_issue("x0");

      // Bypass on operand B only; reg_write=0 passes through
      drive(1'b1, 1'b0, 1'b0, 5'd8, 5'd9, 5'd6, 32'h300, 8'h33, 32'hAAAA0001, 32'hBBBB0002);
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hCAFE;
      push(1'b0, 1'b0, 5'd6, 32'hAAAA0001, 32'hCAFE, 32'h300, 8'h33);
      tick(1'b0, 1'b0);
      check_issue("bypass_b");
      wb_en = 1'b0;

      // Load-use: one stall cycle, one bubble, then the dependent issues
      drive(1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 32'h400, 8'h44, 32'h10, 32'h20);
      push(1'b1, 1'b1, 5'd3, 32'h10, 32'h20, 32'h400, 8'h44);
      tick(1'b0, 1'b0);
      check_issue("load");
      drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd7, 32'h500, 8'h55, 32'h333, 32'h0);
      tick(1'b1, 1'b1);
      check_bubble("loaduse_bubble");
      check_cnts("loaduse");
      push(1'b1, 1'b0, 5'd7, 32'h333, 32'h0, 32'h500, 8'h55);
      tick(1'b0, 1'b0);
      check_issue("loaduse_dep");

      // Back-pressure for three cycles holds everything
      ex_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 5'd12, 5'd13, 5'd14, 32'h600, 8'h66, 32'h6001, 32'h6002);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0);
         check("bp_valid", out_valid, 1'b1);
         cmp_fields("bp_hold", last);
      end
      check_cnts("bp");
      ex_ready = 1'b1;
      push(1'b1, 1'b0, 5'd14, 32'h6001, 32'h6002, 32'h600, 8'h66);
      tick(1'b0, 1'b0);
      check_issue("bp_release");

      // Flush overrides a pending load-use hazard
      drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 32'h700, 8'h77, 32'h0, 32'h0);
      push(1'b1, 1'b1, 5'd9, 32'h0, 32'h0, 32'h700, 8'h77);
      tick(1'b0, 1'b0);
      check_issue("load2");
      drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd9, 5'd15, 32'h800, 8'h88, 32'h1, 32'h2);
      flush = 1'b1;
      tick(1'b0, 1'b0);
      check_bubble("flush_hazard");
      check_cnts("flush_hazard");
      flush = 1'b0;

      // Flush with ex_ready=0 still squashes the held instruction
      drive(1'b1, 1'b1, 1'b0, 5'd16, 5'd17, 5'd11, 32'h900, 8'h99, 32'h9001, 32'h9002);
      push(1'b1, 1'b0, 5'd11, 32'h9001, 32'h9002, 32'h900, 8'h99);
      tick(1'b0, 1'b0);
      check_issue("pre_flush");
      ex_ready = 1'b0; flush = 1'b1;
      tick(1'b0, 1'b0);
      check_bubble("flush_bp");
      flush = 1'b0; ex_ready = 1'b1;

      // Reset asserted mid back-pressure clears state before the next edge
      drive(1'b1, 1'b1, 1'b0, 5'd18, 5'd19, 5'd20, 32'hA00, 8'hAA, 32'hA001, 32'hA002);
      push(1'b1, 1'b0, 5'd20, 32'hA001, 32'hA002, 32'hA00, 8'hAA);
      tick(1'b0, 1'b0);
      check_issue("pre_rst");
      ex_ready = 1'b0;
      tick(1'b1, 1'b0);
      check("pre_rst_hold", out_valid, 1'b1);
      #2;
      rst = 1'b1;
      exp_stall = '0; exp_bubble = '0;
      sb.delete();
      #1;
      check_bubble("rst_async");
      check_cnts("rst_async");
      check("rst_stall_out", stall_out, 1'b0);
      #1;
      rst = 1'b0;
      ex_ready = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 5'd21, 5'd0, 5'd22, 32'hB00, 8'hBB, 32'hB001, 32'hFFFF);
      push(1'b0, 1'b1, 5'd22, 32'hB001, 32'h0, 32'hB00, 8'hBB);
      tick(1'b0, 1'b0);
      check_issue("resume");

      // Long back-pressure saturates stall_cnt
      ex_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0);
      for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
      check_cnts("sat");
      check("sat_max", stall_cnt, CNT_MAX);
      ex_ready = 1'b1;
      tick(1'b0, 1'b0);
      check("drain_valid", out_valid, 1'b0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CNT_W, default 16, width of performance counters.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in_valid/in_reg_write/in_mem_read  input  1 each  decoded-instruction valid, writes rd, is load.
REQ-006 SHALL have ports in_rs1/in_rs2/in_rd  input  5 each  source and destination register numbers.
REQ-007 SHALL have ports in_imm  input  XLEN and in_ctrl  input  8  immediate and opaque ALU/mem control.
REQ-008 SHALL have ports rf_addr_a/rf_addr_b  output  5 each  register-file read addresses.
REQ-009 SHALL have ports rf_data_a/rf_data_b  input  XLEN each  register-file combinational read data.
REQ-010 SHALL have ports wb_en  input  1, wb_addr  input  5, wb_data  input  XLEN  writeback port shared with the register file.
REQ-011 SHALL have ports ex_ready  input  1 and flush  input  1  EX back-pressure and branch squash.
REQ-012 SHALL have port stall_out  output  1  freezes PC and IF/ID register.
REQ-013 SHALL have ports out_valid/out_reg_write/out_mem_read  output  1, out_rd  output  5, out_a/out_b/out_imm  output  XLEN, out_ctrl  output  8  registered ID/EX contents.
REQ-014 SHALL have ports stall_cnt/bubble_cnt  output  CNT_W  saturating performance counters.

Function
REQ-015 SHALL drive rf_addr_a=in_rs1, rf_addr_b=in_rs2 combinationally.
REQ-016 SHALL select operand A: 0 if in_rs1==0; else wb_data if wb_en && wb_addr==in_rs1; else rf_data_a (same for B with in_rs2); bypass covers the register file write landing on the same edge.
REQ-017 SHALL flag hazard = in_valid && out_valid && out_mem_read && out_rd!=0 && (out_rd==in_rs1 || out_rd==in_rs2).
REQ-018 SHALL drive stall_out = !flush && (hazard || (out_valid && !ex_ready)), combinationally.
REQ-019 SHALL, at each rising edge, apply the first matching rule: flush -> out_valid<=0; out_valid && !ex_ready -> hold all outputs; hazard -> out_valid<=0 (bubble), other fields don't-care; else load all outputs from inputs/selected operands, out_valid<=in_valid.
REQ-020 SHALL force out_reg_write and out_mem_read to 0 whenever out_valid is loaded 0.
REQ-021 SHALL make a load-use stall exactly one cycle: the bubble clears out_mem_read, so hazard drops next cycle with no extra state.
REQ-022 SHALL increment stall_cnt on each edge where stall_out=1, and bubble_cnt on each edge where a hazard bubble is inserted; both saturate at all-ones.
REQ-023 SHALL give flush priority over hazard and back-pressure; a flush with ex_ready=0 still squashes the held instruction.
REQ-024 SHALL have latency 1 cycle in-to-out when unstalled; throughput one instruction per cycle.

Reset
REQ-025 SHALL, while rst=1, asynchronously clear every registered output (out_*, stall_cnt, bubble_cnt) to 0; stall_out then follows REQ-018 with out_valid=0.
REQ-026 SHALL resume normal loading on the first rising edge after rst deasserts; an instruction in flight at reset is discarded.

Verification
REQ-027 Bypass: rf_data_a=5, wb_en=1, wb_addr=10, wb_data=0x77, in_rs1=10 -> next edge out_a=0x77.
REQ-028 x0: in_rs2=0, rf_data_b=0xDEAD, wb_en=1, wb_addr=0 -> out_b=0.
REQ-029 Load-use: load with rd=3 in ID/EX, in_rs1=3 -> stall_out=1 one cycle, out_valid=0 next edge, bubble_cnt=1, dependent instruction issues the following edge.
REQ-030 Back-pressure: out_valid=1, ex_ready=0 for 3 cycles -> outputs unchanged, stall_out=1, stall_cnt=3.
REQ-031 Flush+hazard: hazard active and flush=1 -> stall_out=0, out_valid=0, bubble_cnt unchanged.
REQ-032 Reset mid-stall: rst pulsed during back-pressure -> out_valid=0, counters=0 immediately, before next clk edge.
